// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WAIT_W     = 4;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Control half of an accepted request, held from handshake through RESP.
    typedef struct packed {
        logic we;
        logic port;
    } acc_ctl_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant selector: round-robin or port-0 priority with a port-1 starvation guard.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CORE_PRIO = 1,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic decide,
    output logic grant_c
);

    logic              last_grant_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              tie;

    assign tie = valid0 && valid1;

    always_comb begin
        grant_c = PORT_CORE;
        if (valid1 && !valid0) begin
            grant_c = PORT_AUX;
        end else if (tie) begin
            if (CORE_PRIO != 0) begin
                grant_c = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? PORT_AUX : PORT_CORE;
            end else begin
                grant_c = ~last_grant_q;
            end
        end
    end

    // Arbitration history only moves when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_AUX;
            wait_cnt_q   <= '0;
        end else if (decide) begin
            last_grant_q <= grant_c;
            if (grant_c == PORT_AUX) begin
                wait_cnt_q <= '0;
            end else if (tie && (wait_cnt_q < WAIT_W'(MAX_WAIT))) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two masters onto the single-ported data memory: one access per three cycles,
// single-cycle strobes, registered read data and a one-cycle response pulse to the winner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned CORE_PRIO = 1,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              decide;
    logic              grant;
    acc_ctl_t          ctl_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rsp_data;

    dmem_arb_pick #(
        .CORE_PRIO (CORE_PRIO),
        .MAX_WAIT  (MAX_WAIT)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .decide  (decide),
        .grant_c (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A decision in IDLE is always a handshake: the grant only ever points at a valid port.
    always_comb begin
        state_d = state_q;
        decide  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    decide  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = decide && (grant == PORT_CORE);
    assign req1_ready = decide && (grant == PORT_AUX);

    always_comb begin
        sel_we    = req0_we;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (grant == PORT_AUX) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    assign rsp_data = ctl_q.we ? '0 : mem_rdata;

    // Memory-side registers double as the payload latch; they hold only during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (decide) begin
                ctl_q     <= '{we: sel_we, port: grant};
                mem_read  <= ~sel_we;
                mem_write <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                if (ctl_q.port == PORT_AUX) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= rsp_data;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: priority instance tracked by a cycle-level reference model,
// plus a round-robin instance exercised with directed steps.
module tb_dmem_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_load;
    int   n_cmp = 0;
    int   n_err = 0;

    logic          v0, v1, we0, we1, r0, r1, s0, s1, mrd, mwr;
    logic [AW-1:0] a0, a1, maddr;
    logic [DW-1:0] d0, d1, q0, q1, mwd, mrdata;

    logic          bv0, bv1, bwe0, bwe1, br0, br1, bs0, bs1, bmrd, bmwr;
    logic [AW-1:0] ba0, ba1, bmaddr;
    logic [DW-1:0] bd0, bd1, bq0, bq1, bmwd, bmrdata;

    logic [DW-1:0] mem_a [128];
    logic [DW-1:0] mem_b [128];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CORE_PRIO(1), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
        .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
        .rsp0_valid(s0), .rsp0_rdata(q0), .rsp1_valid(s1), .rsp1_rdata(q1),
        .mem_read(mrd), .mem_write(mwr), .mem_addr(maddr), .mem_wdata(mwd), .mem_rdata(mrdata)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CORE_PRIO(0), .MAX_WAIT(MW)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(bv0), .req0_ready(br0), .req0_we(bwe0), .req0_addr(ba0), .req0_wdata(bd0),
        .req1_valid(bv1), .req1_ready(br1), .req1_we(bwe1), .req1_addr(ba1), .req1_wdata(bd1),
        .rsp0_valid(bs0), .rsp0_rdata(bq0), .rsp1_valid(bs1), .rsp1_rdata(bq1),
        .mem_read(bmrd), .mem_write(bmwr), .mem_addr(bmaddr), .mem_wdata(bmwd), .mem_rdata(bmrdata)
    );

    // Memories power up holding their own word index.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= DW'(i);
                mem_b[i] <= DW'(i);
            end
        end else begin
            if (mwr)  mem_a[maddr[6:0]]  <= mwd;
            if (bmwr) mem_b[bmaddr[6:0]] <= bmwd;
        end
    end

    assign mrdata  = mem_a[maddr[6:0]];
    assign bmrdata = mem_b[bmaddr[6:0]];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the priority instance: busy countdown, pending access, wait counter.
    int            m_busy;
    int            m_port;
    int unsigned   m_wc;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_last [2];
    logic [DW-1:0] mmem [128];
    bit            mon_en = 1'b0;

    always @(negedge clk) begin : model
        int win;
        if (mem_load) begin
            for (int i = 0; i < 128; i++) mmem[i] = DW'(i);
        end
        if (!rst_n) begin
            m_busy    = 0;
            m_wc      = 0;
            m_port    = 0;
            m_last[0] = '0;
            m_last[1] = '0;
        end else if (mon_en) begin
            win = -1;
            if (m_busy == 0) begin
                if (v0 && v1)  win = (m_wc == MW) ? 1 : 0;
                else if (v0)   win = 0;
                else if (v1)   win = 1;
            end
            check("m_ready0",     DW'(r0),  DW'(win == 0));
            check("m_ready1",     DW'(r1),  DW'(win == 1));
            check("m_mem_read",   DW'(mrd), DW'(m_busy == 2 && !m_we));
            check("m_mem_write",  DW'(mwr), DW'(m_busy == 2 && m_we));
            check("m_mem_addr",   DW'(maddr), (m_busy == 2) ? DW'(m_addr) : DW'(0));
            check("m_mem_wdata",  mwd, (m_busy == 2) ? m_wdata : DW'(0));
            check("m_rsp0_valid", DW'(s0),  DW'(m_busy == 1 && m_port == 0));
            check("m_rsp1_valid", DW'(s1),  DW'(m_busy == 1 && m_port == 1));
            check("m_rsp0_rdata", q0, m_last[0]);
            check("m_rsp1_rdata", q1, m_last[1]);
            if (m_busy == 2) begin
                m_last[m_port] = m_we ? DW'(0) : mmem[m_addr[6:0]];
                if (m_we) mmem[m_addr[6:0]] = m_wdata;
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_busy = 0;
            end else if (win >= 0) begin
                m_busy  = 2;
                m_port  = win;
                m_we    = (win == 1) ? we1 : we0;
                m_addr  = (win == 1) ? a1  : a0;
                m_wdata = (win == 1) ? d1  : d0;
                if (win == 1)              m_wc = 0;
                else if (v1 && m_wc < MW)  m_wc = m_wc + 1;
            end
        end
    end

    // One directed transfer on the priority instance, checking cycle placement.
    task automatic xfer(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp);
        int n;
        @(posedge clk); #1;
        if (p == 0) begin v0 = 1'b1; we0 = we; a0 = a; d0 = d; end
        else        begin v1 = 1'b1; we1 = we; a1 = a; d1 = d; end
        n = 0;
        @(negedge clk);
        while (((p == 0) ? r0 : r1) !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("xfer_ready", DW'((p == 0) ? r0 : r1), DW'(1));
        @(posedge clk); #1;
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
        @(negedge clk);
        check("xfer_strobe_we", DW'(mwr), DW'(we));
        check("xfer_strobe_re", DW'(mrd), DW'(!we));
        check("xfer_addr",      DW'(maddr), DW'(a));
        check("xfer_rsp_early", DW'(s0 | s1), DW'(0));
        @(negedge clk);
        check("xfer_strobe_off", DW'(mrd | mwr), DW'(0));
        check("xfer_rsp_valid",  DW'((p == 0) ? s0 : s1), DW'(1));
        check("xfer_rsp_other",  DW'((p == 0) ? s1 : s0), DW'(0));
        check("xfer_rsp_rdata",  (p == 0) ? q0 : q1, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, k, last, cyc;
        logic hs0, hs1;
        rst_n = 1'b0; mem_load = 1'b1;
        v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        bv0 = 0; bv1 = 0; bwe0 = 0; bwe1 = 0; ba0 = '0; ba1 = '0; bd0 = '0; bd1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", DW'({r0, r1, br0, br1}), DW'(0));
        check("rst_rsp_valid", DW'({s0, s1, bs0, bs1}), DW'(0));
        check("rst_rsp0_rdata", q0, DW'(0));
        check("rst_rsp1_rdata", q1, DW'(0));
        check("rst_strobes", DW'({mrd, mwr, bmrd, bmwr}), DW'(0));
        check("rst_mem_addr", DW'(maddr), DW'(0));
        check("rst_mem_wdata", mwd, DW'(0));
        check("rst_rr_rdata", bq0 | bq1, DW'(0));
        mem_load = 1'b0; rst_n = 1'b1; mon_en = 1'b1;

        // Port 1 reads initial contents; port 0 outputs untouched.
        xfer(1, 1'b0, AW'(7), DW'(0), DW'(7));
        check("p1_rd_q0_zero", q0, DW'(0));
        // Port 0 write then read back.
        xfer(0, 1'b1, AW'(5), 32'hDEAD_BEEF, DW'(0));
        xfer(0, 1'b0, AW'(5), DW'(0), 32'hDEAD_BEEF);
        check("p0_rd_q1_held", q1, DW'(7));

        // Priority ties: four port-0 wins then one port-1 win, repeating.
        @(posedge clk); #1;
        v0 = 1; v1 = 1; we0 = 0; we1 = 0; a0 = AW'(1); a1 = AW'(2);
        k = 0; last = -1; cyc = 0;
        while (k < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (r0 || r1) begin
                check("prio_grant", DW'(r1), DW'((k % 5) == 4));
                if (last >= 0) check("prio_spacing", DW'(cyc - last), DW'(3));
                last = cyc;
                k++;
            end
        end
        check("prio_count", DW'(k), DW'(10));
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        repeat (4) @(posedge clk);

        // Round-robin ties alternate starting with port 0; stop after port 0 wins.
        #1;
        bv0 = 1; bv1 = 1; bwe0 = 0; bwe1 = 0; ba0 = AW'(1); ba1 = AW'(2);
        k = 0; last = -1; cyc = 0;
        while (k < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (br0 || br1) begin
                check("rr_grant", DW'(br1), DW'((k % 2) == 1));
                if (last >= 0) check("rr_spacing", DW'(cyc - last), DW'(3));
                last = cyc;
                k++;
            end
        end
        check("rr_count", DW'(k), DW'(5));
        @(posedge clk); #1;
        bv0 = 0; bv1 = 0;
        repeat (4) @(posedge clk);

        // Reset during the ACCESS cycle of a write.
        #1;
        bv0 = 1; bwe0 = 1; ba0 = AW'(20); bd0 = 32'hA5A5_0001;
        n = 0;
        @(negedge clk);
        while (br0 !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        check("rstw_ready", DW'(br0), DW'(1));
        @(posedge clk); #1;
        bv0 = 0;
        check("rstw_strobe", DW'(bmwr), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rstw_drop", DW'(bmwr), DW'(0));
        check("rstw_rsp_none", DW'(bs0 | bs1), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_after_rsp", DW'({bs0, bs1, br0, br1}), DW'(0));
        check("rstw_after_mem", DW'({bmrd, bmwr}), DW'(0));
        check("rstw_after_addr", DW'(bmaddr) | bmwd, DW'(0));
        check("rstw_after_rdata", bq0 | bq1, DW'(0));
        // First tie after reset goes to port 0; the aborted write never landed.
        @(posedge clk); #1;
        bv0 = 1; bv1 = 1; bwe0 = 0; bwe1 = 0; ba0 = AW'(20); ba1 = AW'(21);
        @(negedge clk);
        check("rstw_tie_r0", DW'(br0), DW'(1));
        check("rstw_tie_r1", DW'(br1), DW'(0));
        @(posedge clk); #1;
        bv0 = 0;
        @(negedge clk);
        @(negedge clk);
        check("rstw_rd_valid", DW'(bs0), DW'(1));
        check("rstw_rd_data", bq0, DW'(20));
        @(negedge clk);
        check("rr_next_r1", DW'(br1), DW'(1));
        @(posedge clk); #1;
        bv1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("rr_p1_valid", DW'(bs1), DW'(1));
        check("rr_p1_data", bq1, DW'(21));

        // Port 1 abandons a request while port 0 is in flight.
        @(posedge clk); #1;
        v0 = 1; we0 = 0; a0 = AW'(3);
        @(negedge clk);
        check("drop_r0", DW'(r0), DW'(1));
        @(posedge clk); #1;
        v0 = 0; v1 = 1; we1 = 1; a1 = AW'(4); d1 = 32'h1234_5678;
        @(posedge clk); #1;
        v1 = 0;
        repeat (6) begin
            @(negedge clk);
            check("drop_no_r1", DW'(r1), DW'(0));
            check("drop_no_s1", DW'(s1), DW'(0));
            check("drop_no_strobe", DW'({mrd, mwr}), DW'(0));
        end
        check("drop_mem", mem_a[4], DW'(4));

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            hs0 = v0 && r0;
            hs1 = v1 && r1;
            @(posedge clk); #1;
            if (hs0 || !v0) begin
                v0 = ($urandom_range(0, 3) != 0);
                we0 = 1'($urandom_range(0, 1));
                a0 = AW'($urandom_range(0, 127));
                d0 = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                v0 = 1'b0;
            end
            if (hs1 || !v1) begin
                v1 = ($urandom_range(0, 3) != 0);
                we1 = 1'($urandom_range(0, 1));
                a1 = AW'($urandom_range(0, 127));
                d1 = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                v1 = 1'b0;
            end
        end
        v0 = 0; v1 = 0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-ported data memory (128 × 32-bit words, 9-bit address, level-sensitive MemRead/MemWrite strobes, combinational read). Port 0 is the core load/store unit. Port 1 is a secondary master (debug/DMA loader). The block grants one request at a time, drives the memory strobes for exactly one cycle, registers the read data, and returns a one-cycle response pulse to the winner. Fixed-priority mode includes a starvation guard for port 1.

## Interface
Parameters:
- ADDR_W, 9, memory address width
- DATA_W, 32, data width
- CORE_PRIO, 1, 1 = port 0 fixed priority with starvation guard; 0 = strict round-robin
- MAX_WAIT, 4, port-1 losses tolerated before a forced port-1 grant (CORE_PRIO=1 only); range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data, valid with rsp pulse
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_addr  out  ADDR_W  to addr
- mem_wdata  out  DATA_W  to write_data
- mem_rdata  in  DATA_W  from read_data

## Operation
- FSM states and transitions:
  - IDLE: if any valid, go to ACCESS; otherwise stay in IDLE.
  - ACCESS: always go to RESP.
  - RESP: always go to IDLE.
- Handshake: reqN_ready = (state==IDLE) && grant==N. It is combinational from the valids and arbitration state. A transfer occurs on valid && ready. Requesters hold valid and payload stable until ready; deasserting earlier is legal and discards the request.
- On handshake, latch we, addr, wdata and the granted port index.
- Arbitration in IDLE:
  - Only one valid: that port wins.
  - Both valid, CORE_PRIO=0: the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
  - Both valid, CORE_PRIO=1: port 0 wins unless wait_cnt == MAX_WAIT, in which case port 1 wins.
- wait_cnt (4 bits):
  - Increments on each tie lost by port 1.
  - Clears on any port-1 grant.
  - Saturates at MAX_WAIT.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_write = latched we; mem_read = !latched we.
  - mem_rdata is registered at the end of the cycle. Writes register 0.
- RESP:
  - rspN_valid is asserted only for the latched port.
  - rspN_rdata holds the registered data and stays stable until the next RESP for that port.
  - rdata is 0 after a write.
- Outside ACCESS, mem_read, mem_write, mem_addr and mem_wdata are all 0. No strobe ever lasts more than one cycle.

## Timing
- Handshake at cycle T: memory strobe at T+1, response pulse at T+2. The earliest next ready is T+3. Throughput is one access per 3 cycles.
- Reset values:
  - state IDLE, last_grant 1, wait_cnt 0.
  - All ready, rsp_valid, rdata and mem_* outputs are 0.
- Reset mid-operation: outputs clear asynchronously, including a mem_write strobe already in progress. No response is issued for the aborted request, and the requester must reissue it.
- A valid asserted during ACCESS or RESP waits. It is arbitrated in the next IDLE cycle.
- Back-to-back requests from the same port are legal. The next ready can coincide with the cycle after that port's rsp pulse.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - port index constants PORT_CORE=0, PORT_AUX=1
  - default ADDR_W/DATA_W
- Sub-module dmem_arb_pick: combinational/sequential 2-way grant selector.
  - Contains last_grant and wait_cnt.
  - Inputs: valids, a decide strobe (IDLE && any valid), CORE_PRIO and MAX_WAIT.
  - Output: grant index.
- The top level holds the FSM, payload latches and the read-data registers.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5. Required response:
  - mem_write high exactly at T+1.
  - rsp0_valid at T+2.
  - Read returns rsp0_rdata=0xDEADBEEF.
- Port 1 reads addr 7 with memory at its initial contents. Required response: rsp1_rdata=7 at T+2, and the port-0 outputs stay 0.
- CORE_PRIO=0, both ports hold valid continuously. Required response: grants alternate 0,1,0,1, and the ready pulses are 3 cycles apart.
- CORE_PRIO=1, MAX_WAIT=4, both ports hold valid. Required response:
  - Port 0 wins 4 times, then port 1 wins once.
  - wait_cnt returns to 0, and the pattern repeats.
- rst_n asserted during the ACCESS cycle of a write. Required response:
  - mem_write drops immediately and no rsp pulse occurs.
  - After release, all outputs are 0 and the first tie goes to port 0.
- Port 1 drops valid before ready while port 0 is being served. Required response: no port-1 access, and no memory strobe for port 1.
